// File: rtl/sonic_vc_pkg.sv
// -----------------------------------------------------------------------------
// sonic_vc_pkg
// Shared types and constants for the SONIC virtual-channel packet path.
//   VC_DATA_W / VC_EMPTY_W : default Avalon-ST data and empty widths
//   vc_beat_t              : one Avalon-ST beat (payload plus sideband)
//   arb_state_t            : packet-lock state of the 2:1 arbiter
//   rr_pick()              : unlocked round-robin choice between two requests
// -----------------------------------------------------------------------------
package sonic_vc_pkg;

    localparam int VC_DATA_W  = 128;
    localparam int VC_EMPTY_W = 2;

    typedef struct packed {
        logic [VC_DATA_W-1:0]  data;
        logic                  error;
        logic                  sop;
        logic                  eop;
        logic [VC_EMPTY_W-1:0] empty;
    } vc_beat_t;

    typedef enum logic {
        ARB_OPEN   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // With a single requester it wins outright. With both requesting, ptr decides.
    // With none requesting the pointer is returned so the grant stays well defined.
    function automatic logic rr_pick(input logic [1:0] req, input logic ptr);
        logic pick;
        pick = ptr;
        if (req == 2'b10) begin
            pick = 1'b1;
        end else if (req == 2'b01) begin
            pick = 1'b0;
        end
        return pick;
    endfunction

endpackage

// File: rtl/sonic_vc_rr_arbiter_2.sv
// -----------------------------------------------------------------------------
// sonic_vc_rr_arbiter_2
// Two-way round-robin arbiter with packet locking. The grant is combinational
// from the current requests so a new packet can start the cycle after the
// previous EOP. The lock state, locked port and round-robin pointer live here.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   req[1:0]      : per-port valid
//   accept        : a beat from the granted port is transferred this cycle
//   accept_eop    : that beat carries EOP
//   grant         : granted port index (0/1)
// -----------------------------------------------------------------------------
module sonic_vc_rr_arbiter_2
    import sonic_vc_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       accept,
    input  logic       accept_eop,
    output logic       grant
);

    arb_state_t state;
    arb_state_t state_next;
    logic       locked_port;
    logic       locked_port_next;
    logic       rr_ptr;
    logic       rr_ptr_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ARB_OPEN;
            locked_port <= 1'b0;
            rr_ptr      <= 1'b0;
        end else begin
            state       <= state_next;
            locked_port <= locked_port_next;
            rr_ptr      <= rr_ptr_next;
        end
    end

    // Any accepted non-EOP beat locks onto its port, whether or not it was SOP,
    // and an EOP releases the lock and hands priority to the other port. A
    // single-beat packet therefore never locks but still flips the pointer.
    always_comb begin
        state_next       = state;
        locked_port_next = locked_port;
        rr_ptr_next      = rr_ptr;
        grant            = (state == ARB_LOCKED) ? locked_port : rr_pick(req, rr_ptr);

        if (accept) begin
            if (accept_eop) begin
                state_next  = ARB_OPEN;
                rr_ptr_next = ~grant;
            end else begin
                state_next       = ARB_LOCKED;
                locked_port_next = grant;
            end
        end
    end

endmodule

// File: rtl/sonic_vc_packet_mux.sv
// -----------------------------------------------------------------------------
// sonic_vc_packet_mux
// 2:1 Avalon-ST packet multiplexer feeding the SONIC multiplexer timing
// adapter. Packet-granular round-robin between two sinks, registered output,
// ready latency 0 on both sides. Each output beat is tagged with its source
// port on out_channel.
// Ports:
//   clk, reset_n                         : clock, asynchronous active-low reset
//   in0_* / in1_*                        : Avalon-ST sinks (ready, valid, data,
//                                          error, startofpacket, endofpacket, empty)
//   out_ready                            : downstream ready
//   out_valid, out_data, out_channel,
//   out_error, out_startofpacket,
//   out_endofpacket, out_empty           : Avalon-ST source
// -----------------------------------------------------------------------------
module sonic_vc_packet_mux
    import sonic_vc_pkg::*;
#(
    parameter int DATA_W  = VC_DATA_W,
    parameter int EMPTY_W = VC_EMPTY_W
) (
    input  logic               clk,
    input  logic               reset_n,

    output logic               in0_ready,
    input  logic               in0_valid,
    input  logic [DATA_W-1:0]  in0_data,
    input  logic               in0_error,
    input  logic               in0_startofpacket,
    input  logic               in0_endofpacket,
    input  logic [EMPTY_W-1:0] in0_empty,

    output logic               in1_ready,
    input  logic               in1_valid,
    input  logic [DATA_W-1:0]  in1_data,
    input  logic               in1_error,
    input  logic               in1_startofpacket,
    input  logic               in1_endofpacket,
    input  logic [EMPTY_W-1:0] in1_empty,

    input  logic               out_ready,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_channel,
    output logic               out_error,
    output logic               out_startofpacket,
    output logic               out_endofpacket,
    output logic [EMPTY_W-1:0] out_empty
);

    vc_beat_t in0_beat;
    vc_beat_t in1_beat;
    vc_beat_t sel_beat;
    vc_beat_t out_beat;
    logic     load;
    logic     grant;
    logic     accept;

    assign in0_beat = '{data:  in0_data,
                        error: in0_error,
                        sop:   in0_startofpacket,
                        eop:   in0_endofpacket,
                        empty: in0_empty};

    assign in1_beat = '{data:  in1_data,
                        error: in1_error,
                        sop:   in1_startofpacket,
                        eop:   in1_endofpacket,
                        empty: in1_empty};

    // The output register can take a new beat when it is empty or being drained.
    assign load = !out_valid || out_ready;

    // Ready is gated by reset_n so neither sink sees ready while reset is held,
    // even though the emptied output register would otherwise allow a load.
    assign in0_ready = reset_n && load && !grant;
    assign in1_ready = reset_n && load &&  grant;

    assign sel_beat = grant ? in1_beat : in0_beat;
    assign accept   = grant ? (in1_valid && in1_ready) : (in0_valid && in0_ready);

    sonic_vc_rr_arbiter_2 u_arbiter (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        ({in1_valid, in0_valid}),
        .accept     (accept),
        .accept_eop (sel_beat.eop),
        .grant      (grant)
    );

    // Payload only updates on an accept; when loading with nothing accepted
    // just out_valid drops and the stale payload is left in place.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid   <= 1'b0;
            out_beat    <= '0;
            out_channel <= 1'b0;
        end else if (load) begin
            out_valid <= accept;
            if (accept) begin
                out_beat    <= sel_beat;
                out_channel <= grant;
            end
        end
    end

    assign out_data          = out_beat.data;
    assign out_error         = out_beat.error;
    assign out_startofpacket = out_beat.sop;
    assign out_endofpacket   = out_beat.eop;
    assign out_empty         = out_beat.empty;

endmodule

// File: tb/tb_sonic_vc_packet_mux.sv
// -----------------------------------------------------------------------------
// tb_sonic_vc_packet_mux
// Directed bench for sonic_vc_packet_mux. Expected beats are queued by the
// stimulus and popped by an output monitor on every out_valid && out_ready.
// -----------------------------------------------------------------------------
module tb_sonic_vc_packet_mux;

    localparam int DW      = 128;
    localparam int EW      = 2;
    localparam int TIMEOUT = 40;

    logic          clk = 1'b0;
    logic          reset_n;

    logic          in0_ready, in0_valid, in0_error, in0_startofpacket, in0_endofpacket;
    logic [DW-1:0] in0_data;
    logic [EW-1:0] in0_empty;
    logic          in1_ready, in1_valid, in1_error, in1_startofpacket, in1_endofpacket;
    logic [DW-1:0] in1_data;
    logic [EW-1:0] in1_empty;
    logic          out_ready, out_valid, out_channel, out_error;
    logic          out_startofpacket, out_endofpacket;
    logic [DW-1:0] out_data;
    logic [EW-1:0] out_empty;

    always #5 clk = ~clk;

    sonic_vc_packet_mux #(.DATA_W(DW), .EMPTY_W(EW)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .in0_ready         (in0_ready),
        .in0_valid         (in0_valid),
        .in0_data          (in0_data),
        .in0_error         (in0_error),
        .in0_startofpacket (in0_startofpacket),
        .in0_endofpacket   (in0_endofpacket),
        .in0_empty         (in0_empty),
        .in1_ready         (in1_ready),
        .in1_valid         (in1_valid),
        .in1_data          (in1_data),
        .in1_error         (in1_error),
        .in1_startofpacket (in1_startofpacket),
        .in1_endofpacket   (in1_endofpacket),
        .in1_empty         (in1_empty),
        .out_ready         (out_ready),
        .out_valid         (out_valid),
        .out_data          (out_data),
        .out_channel       (out_channel),
        .out_error         (out_error),
        .out_startofpacket (out_startofpacket),
        .out_endofpacket   (out_endofpacket),
        .out_empty         (out_empty)
    );

    typedef struct {
        logic [7:0] data;
        logic       ch;
        logic       sop;
        logic       eop;
        logic [1:0] empty;
        logic       err;
    } exp_t;

    exp_t       exp_q[$];
    int         fire_cyc[$];
    logic [7:0] fire_data[$];
    int         checks     = 0;
    int         failures   = 0;
    int         cyc        = 0;
    int         fire_count = 0;
    int         p0_acc     = 0;
    int         p1_acc     = 0;
    bit         abort_drv  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic pushExp(input logic [7:0] data, input logic ch, input logic sop,
                           input logic eop, input logic [1:0] empty, input logic err);
        exp_t e;
        e.data  = data;
        e.ch    = ch;
        e.sop   = sop;
        e.eop   = eop;
        e.empty = empty;
        e.err   = err;
        exp_q.push_back(e);
    endtask

    // Queue the expected beats of an n-beat packet starting at data base.
    task automatic pushPacket(input logic [7:0] base, input logic ch, input int n,
                              input logic [1:0] last_empty, input logic last_err);
        for (int i = 0; i < n; i++) begin
            pushExp(8'(base + 8'(i)), ch, i == 0, i == n - 1,
                    (i == n - 1) ? last_empty : 2'd0,
                    (i == n - 1) ? last_err : 1'b0);
        end
    endtask

    // Output monitor / scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && out_valid && out_ready) begin
            fire_count++;
            fire_cyc.push_back(cyc);
            fire_data.push_back(out_data[7:0]);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_beat: got data 0x%0h, expected no beat", out_data);
            end else begin
                e = exp_q.pop_front();
                checkOutput("beat_data", out_data, 128'(e.data));
                checkOutput("beat_side",
                            128'({out_channel, out_startofpacket, out_endofpacket, out_empty, out_error}),
                            128'({e.ch, e.sop, e.eop, e.empty, e.err}));
            end
        end
    end

    function automatic int cycleOf(input logic [7:0] data);
        for (int i = fire_data.size() - 1; i >= 0; i--) begin
            if (fire_data[i] == data) return fire_cyc[i];
        end
        return -1000;
    endfunction

    task automatic driveBeat(input int port, input logic valid, input logic [7:0] data,
                             input logic sop, input logic eop, input logic [1:0] empty,
                             input logic err);
        if (port == 0) begin
            in0_valid = valid; in0_data = 128'(data); in0_startofpacket = sop;
            in0_endofpacket = eop; in0_empty = empty; in0_error = err;
        end else begin
            in1_valid = valid; in1_data = 128'(data); in1_startofpacket = sop;
            in1_endofpacket = eop; in1_empty = empty; in1_error = err;
        end
    endtask

    // Packet driver: presents each beat until the DUT accepts it.
    task automatic applyStimulus(input int port, input logic [7:0] base, input int n,
                                 input logic [1:0] last_empty, input logic last_err);
        for (int i = 0; i < n; i++) begin
            logic acc;
            int   waited;
            driveBeat(port, 1'b1, 8'(base + 8'(i)), i == 0, i == n - 1,
                      (i == n - 1) ? last_empty : 2'd0,
                      (i == n - 1) ? last_err : 1'b0);
            acc    = 1'b0;
            waited = 0;
            while (!acc) begin
                if (abort_drv) begin
                    driveBeat(port, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0);
                    return;
                end
                @(negedge clk);
                acc = (port == 0) ? (in0_valid && in0_ready) : (in1_valid && in1_ready);
                @(posedge clk);
                #1;
                waited++;
                if (!acc && waited > TIMEOUT) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL accept_timeout: port %0d beat 0x%0h not accepted, expected accept", port, 8'(base + 8'(i)));
                    driveBeat(port, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0);
                    return;
                end
            end
            if (port == 0) p0_acc++;
            else           p1_acc++;
        end
        driveBeat(port, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic waitDrain();
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 60) begin
            @(posedge clk);
            waited++;
        end
        checkOutput("drain_left", 128'(exp_q.size()), 128'(0));
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int fc0;
        int n;
        bit done;

        out_ready = 1'b1;
        reset_n   = 1'b0;

        // 1. Reset with both sinks valid; port 0 wins first after release.
        driveBeat(0, 1'b1, 8'h10, 1'b1, 1'b1, 2'd0, 1'b0);
        driveBeat(1, 1'b1, 8'h11, 1'b1, 1'b1, 2'd0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_out_valid", 128'(out_valid), 128'(0));
        checkOutput("rst_in0_ready", 128'(in0_ready), 128'(0));
        checkOutput("rst_in1_ready", 128'(in1_ready), 128'(0));
        checkOutput("rst_out_data", out_data, 128'(0));
        checkOutput("rst_out_channel", 128'(out_channel), 128'(0));
        pushExp(8'h10, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0);
        pushExp(8'h11, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("first_grant_in0_ready", 128'(in0_ready), 128'(1));
        checkOutput("first_grant_in1_ready", 128'(in1_ready), 128'(0));
        @(posedge clk);
        #1;
        driveBeat(0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0);
        @(negedge clk);
        checkOutput("second_grant_in1_ready", 128'(in1_ready), 128'(1));
        @(posedge clk);
        #1;
        driveBeat(1, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0);
        waitDrain();

        // 2. Two contending 3-beat packets, back to back with no gap.
        pushPacket(8'hA0, 1'b0, 3, 2'd0, 1'b0);
        pushPacket(8'hB0, 1'b1, 3, 2'd0, 1'b0);
        fork
            applyStimulus(0, 8'hA0, 3, 2'd0, 1'b0);
            applyStimulus(1, 8'hB0, 3, 2'd0, 1'b0);
        join
        waitDrain();
        checkOutput("t2_no_gap", 128'(cycleOf(8'hB2) - cycleOf(8'hA0)), 128'(5));

        // 3. Single-beat packet on port 1, then a contended pair goes to port 0 first.
        pushPacket(8'hC0, 1'b1, 1, 2'd2, 1'b0);
        applyStimulus(1, 8'hC0, 1, 2'd2, 1'b0);
        waitDrain();
        pushPacket(8'hD0, 1'b0, 1, 2'd0, 1'b0);
        pushPacket(8'hE0, 1'b1, 1, 2'd1, 1'b1);
        fork
            applyStimulus(0, 8'hD0, 1, 2'd0, 1'b0);
            applyStimulus(1, 8'hE0, 1, 2'd1, 1'b1);
        join
        waitDrain();

        // 4. Backpressure for 4 cycles while beat 0x42 sits in the output register.
        pushPacket(8'h40, 1'b0, 4, 2'd3, 1'b0);
        fc0 = fire_count;
        fork
            applyStimulus(0, 8'h40, 4, 2'd3, 1'b0);
            begin
                n = 0;
                while (fire_count < fc0 + 2 && n < TIMEOUT) begin
                    @(posedge clk);
                    n++;
                end
                #1;
                out_ready = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    checkOutput("bp_out_valid", 128'(out_valid), 128'(1));
                    checkOutput("bp_out_data", out_data, 128'(8'h42));
                    checkOutput("bp_in0_ready", 128'(in0_ready), 128'(0));
                    checkOutput("bp_in1_ready", 128'(in1_ready), 128'(0));
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        waitDrain();

        // 5. Port 1 waits for port 0's locked 4-beat packet to finish.
        pushPacket(8'h50, 1'b0, 4, 2'd0, 1'b0);
        pushPacket(8'h60, 1'b1, 2, 2'd0, 1'b0);
        fork
            applyStimulus(0, 8'h50, 4, 2'd0, 1'b0);
            begin
                @(posedge clk);
                #1;
                applyStimulus(1, 8'h60, 2, 2'd0, 1'b0);
            end
            begin
                n    = 0;
                done = 1'b0;
                while (!done && n < TIMEOUT) begin
                    @(negedge clk);
                    n++;
                    if (in0_valid && in0_ready && in0_endofpacket) done = 1'b1;
                    else if (in1_valid) checkOutput("lock_in1_ready", 128'(in1_ready), 128'(0));
                end
                checkOutput("lock_eop_seen", 128'(done), 128'(1));
            end
        join
        waitDrain();
        checkOutput("t5_sop_next_cycle", 128'(cycleOf(8'h60) - cycleOf(8'h53)), 128'(1));

        // 6. Reset after beat 2 of 4; port 1 is granted right after release.
        pushExp(8'h70, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
        p0_acc    = 0;
        abort_drv = 1'b0;
        fork
            applyStimulus(0, 8'h70, 4, 2'd0, 1'b0);
            begin
                n = 0;
                while (p0_acc < 2 && n < TIMEOUT) begin
                    @(posedge clk);
                    #2;
                    n++;
                end
                reset_n   = 1'b0;
                abort_drv = 1'b1;
            end
        join
        @(negedge clk);
        checkOutput("t6_rst_out_valid", 128'(out_valid), 128'(0));
        checkOutput("t6_rst_in0_ready", 128'(in0_ready), 128'(0));
        checkOutput("t6_rst_in1_ready", 128'(in1_ready), 128'(0));
        pushPacket(8'h80, 1'b1, 2, 2'd0, 1'b0);
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        abort_drv = 1'b0;
        fork
            applyStimulus(1, 8'h80, 2, 2'd0, 1'b0);
            begin
                @(negedge clk);
                checkOutput("t6_in1_ready_after_rst", 128'(in1_ready), 128'(1));
                checkOutput("t6_in0_ready_after_rst", 128'(in0_ready), 128'(0));
            end
        join
        waitDrain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "[TB] global timeout");
    end

endmodule
